debug_view_sel: RTL and testbench

- Parametrised successor to the MIPS board debug-display selector.
- Chooses one of NCH WIDTH-bit datapath probes (Rdata1, Rdata2, Result, Wdata, NextPC, newPC, …) for the 7-seg/LED display path and drives a one-hot channel LED.
- Channel selection comes from debounced NEXT/PREV push buttons or from a timed auto-scan mode.
- FREEZE latches the displayed value. All outputs are registered.

---
 rtl/debug_view_sel_pkg.sv | 13 +
 rtl/btn_debounce.sv | 29 ++
 rtl/debug_view_sel.sv | 78 +++++++
 tb/tb_debug_view_sel.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_view_sel_pkg.sv
// debug_view_sel_pkg: default probe geometry and channel indices for the debug display selector.
package debug_view_sel_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH = 6;
    typedef enum logic [3:0] {
        CH_RDATA1 = 4'd0,
        CH_RDATA2 = 4'd1,
        CH_RESULT = 4'd2,
        CH_WDATA  = 4'd3,
        CH_NEXTPC = 4'd4,
        CH_NEWPC  = 4'd5
    } ch_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and press-edge pulse for one raw button.
module btn_debounce #(
    parameter int DB_CNT = 1000000
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic IN,
    output logic LEVEL,
    output logic RISE
);
    localparam int CW = DB_CNT > 1 ? $clog2(DB_CNT) : 1;
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic done;
    assign done = sync[1] != LEVEL && cnt == CW'(DB_CNT - 1);
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync <= '0;
            cnt <= '0;
            LEVEL <= 1'b0;
            RISE <= 1'b0;
        end else begin
            sync <= {sync[0], IN};
            cnt <= (sync[1] == LEVEL || done) ? '0 : cnt + 1'b1;
            LEVEL <= done ? sync[1] : LEVEL;
            RISE <= done & sync[1];
        end
    end
endmodule

// File: rtl/debug_view_sel.sv
// debug_view_sel: picks one of NCH probes for the display, stepped by debounced buttons or auto-scan,
// with FREEZE holding selection, divider and registered outputs.
module debug_view_sel
    import debug_view_sel_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH = DEF_NCH,
    parameter int SELW = 4,
    parameter int DB_CNT = 1000000,
    parameter int SCAN_DIV = 50000000
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [NCH*WIDTH-1:0] DIN,
    input  logic                 BTN_NEXT,
    input  logic                 BTN_PREV,
    input  logic                 MODE_SCAN,
    input  logic                 FREEZE,
    output logic [SELW-1:0]      SEL,
    output logic [NCH-1:0]       SEL_LED,
    output logic [WIDTH-1:0]     Vdata
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);
    logic next_rise, prev_rise, next_level_unused, prev_level_unused;
    logic [1:0] scan_sync, frz_sync;
    logic scan, frz, scan_prev, div_end;
    logic [DW-1:0] div;
    logic [SELW-1:0] sel, sel_inc, sel_dec;

    btn_debounce #(.DB_CNT(DB_CNT)) u_next (
        .CLK(CLK), .RSTN(RSTN), .IN(BTN_NEXT), .LEVEL(next_level_unused), .RISE(next_rise)
    );
    btn_debounce #(.DB_CNT(DB_CNT)) u_prev (
        .CLK(CLK), .RSTN(RSTN), .IN(BTN_PREV), .LEVEL(prev_level_unused), .RISE(prev_rise)
    );

    assign scan = scan_sync[1];
    assign frz = frz_sync[1];
    assign div_end = div == DW'(SCAN_DIV - 1);
    // explicit compare against NCH-1 keeps sel in range for non-power-of-two NCH
    assign sel_inc = sel == LAST ? '0 : sel + 1'b1;
    assign sel_dec = sel == '0 ? LAST : sel - 1'b1;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            scan_sync <= '0;
            frz_sync <= '0;
            scan_prev <= 1'b0;
            div <= '0;
            sel <= '0;
        end else begin
            scan_sync <= {scan_sync[0], MODE_SCAN};
            frz_sync <= {frz_sync[0], FREEZE};
            if (!frz) begin
                scan_prev <= scan;
                if (scan) begin
                    div <= (!scan_prev || div_end) ? '0 : div + 1'b1;
                    sel <= (scan_prev && div_end) ? sel_inc : sel;
                end else if (next_rise != prev_rise) begin
                    sel <= next_rise ? sel_inc : sel_dec;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            SEL <= '0;
            SEL_LED <= NCH'(1);
            Vdata <= '0;
        end else if (!frz) begin
            SEL <= sel;
            SEL_LED <= NCH'(1) << sel;
            Vdata <= DIN[int'(sel) * WIDTH +: WIDTH];
        end
    end
endmodule

// File: tb/tb_debug_view_sel.sv
// tb_debug_view_sel: scenario-driven scoreboard bench for debug_view_sel (NCH=6, DB_CNT=4, SCAN_DIV=8).
module tb_debug_view_sel;
    import debug_view_sel_pkg::*;
    typedef struct packed {
        logic [3:0]  sel;
        logic [5:0]  led;
        logic [31:0] vdata;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic btn_next = 1'b0, btn_prev = 1'b0, mode_scan = 1'b0, freeze = 1'b0;
    logic [31:0] probe [6];
    logic [191:0] din;
    logic [3:0] sel;
    logic [5:0] sel_led;
    logic [31:0] vdata;
    exp_t sb [$];
    int m_sel = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    always_comb for (int k = 0; k < 6; k++) din[k*32 +: 32] = probe[k];

    debug_view_sel #(.WIDTH(32), .NCH(6), .SELW(4), .DB_CNT(4), .SCAN_DIV(8)) dut (
        .CLK(clk), .RSTN(rstn), .DIN(din), .BTN_NEXT(btn_next), .BTN_PREV(btn_prev),
        .MODE_SCAN(mode_scan), .FREEZE(freeze), .SEL(sel), .SEL_LED(sel_led), .Vdata(vdata)
    );

    function automatic exp_t model();
        return '{sel: 4'(m_sel), led: 6'(1) << m_sel, vdata: probe[m_sel]};
    endfunction

    function automatic exp_t obs();
        return '{sel: sel, led: sel_led, vdata: vdata};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        tick(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        exp_t e, o;
        #1 rstn = 1'b0;
        tick(2);
        sb.push_back('{sel: 4'd0, led: 6'b000001, vdata: 32'h0});
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_hold got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        rstn = 1'b1;
        sb.push_back('{sel: 4'd0, led: 6'b000001, vdata: 32'h1000_0000});
        tick(1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_release got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
    endtask

    task automatic test_manual();
        exp_t e, o;
        sb.push_back(model());
        btn_next = 1'b1;
        tick(7);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL next_early got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        m_sel = 1;
        sb.push_back('{sel: 4'd1, led: 6'b000010, vdata: 32'h1000_0001});
        tick(1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL next_latency got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        tick(2);
        btn_next = 1'b0;
        tick(10);
        sb.push_back(model());
        btn_next = 1'b1;
        tick(3);
        btn_next = 1'b0;
        tick(12);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL glitch got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
    endtask

    task automatic test_wrap();
        exp_t e, o;
        for (int i = 0; i < 5; i++) begin
            m_sel = (m_sel + 1) % 6;
            sb.push_back(model());
            press(1'b1, 1'b0);
            e = sb.pop_front(); o = obs(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL next_step%0d got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", i, o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
            end
        end
        m_sel = 5;
        sb.push_back('{sel: 4'd5, led: 6'b100000, vdata: 32'h1000_0005});
        press(1'b0, 1'b1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL wrap_prev got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        sb.push_back(model());
        press(1'b1, 1'b1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL next_prev_same got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
    endtask

    task automatic test_scan();
        exp_t e, o;
        m_sel = 4;
        sb.push_back(model());
        press(1'b0, 1'b1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL prev_to_4 got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        mode_scan = 1'b1;
        sb.push_back(model());
        tick(11);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scan_pre got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        m_sel = 5;
        sb.push_back(model());
        tick(1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scan_first got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        for (int i = 0; i < 2; i++) begin
            sb.push_back(model());
            tick(7);
            e = sb.pop_front(); o = obs(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL scan_hold%0d got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", i, o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
            end
            m_sel = (m_sel + 1) % 6;
            sb.push_back(model());
            tick(1);
            e = sb.pop_front(); o = obs(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL scan_step%0d got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", i, o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
            end
        end
        btn_next = 1'b1;
        m_sel = 2;
        sb.push_back(model());
        tick(8);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scan_btn_ignored got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        btn_next = 1'b0;
        m_sel = 3;
        sb.push_back(model());
        tick(8);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scan_after_btn got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        mode_scan = 1'b0;
        sb.push_back(model());
        tick(10);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL scan_exit_keep got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
    endtask

    task automatic test_freeze();
        exp_t e, o;
        m_sel = 2;
        sb.push_back(model());
        press(1'b0, 1'b1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL prev_to_2 got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        freeze = 1'b1;
        tick(3);
        probe[CH_RESULT] = 32'hDEAD_BEEF;
        sb.push_back('{sel: 4'd2, led: 6'b000100, vdata: 32'h1000_0002});
        press(1'b1, 1'b0);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL freeze_hold got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        freeze = 1'b0;
        sb.push_back('{sel: 4'd2, led: 6'b000100, vdata: 32'hDEAD_BEEF});
        tick(3);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL unfreeze got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        probe[CH_RESULT] = 32'h1234_5678;
        sb.push_back(model());
        tick(1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL live_track got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        probe[CH_RESULT] = 32'h1000_0002;
        tick(1);
    endtask

    task automatic test_reset_mid_scan();
        exp_t e, o;
        mode_scan = 1'b1;
        tick(8);
        #2 rstn = 1'b0;
        #1;
        m_sel = 0;
        sb.push_back('{sel: 4'd0, led: 6'b000001, vdata: 32'h0});
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL reset_async got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        tick(1);
        rstn = 1'b1;
        sb.push_back(model());
        tick(11);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL post_reset_pre got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        m_sel = 1;
        sb.push_back(model());
        tick(1);
        e = sb.pop_front(); o = obs(); vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL post_reset_step got sel=%0d led=%b v=%h exp sel=%0d led=%b v=%h", o.sel, o.led, o.vdata, e.sel, e.led, e.vdata);
        end
        mode_scan = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 6; k++) probe[k] = 32'h1000_0000 + k;
        test_reset();
        test_manual();
        test_wrap();
        test_scan();
        test_freeze();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
